// File: rtl/speck_round_engine.sv
// speck_round_engine
//   Iterative SPECK round engine. Runs up to MAX_ROUNDS encrypt or decrypt
//   rounds on one 2*WORD_SIZE block, fetching one subkey per round via a
//   request/valid handshake with the key store.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              operation request, sampled only when idle
//   decrypt            0 = encrypt, 1 = decrypt (sampled with start)
//   num_rounds         rounds to run, clamped to MAX_ROUNDS (sampled with start)
//   data_in            input block {x, y} (sampled with start)
//   key_req / key_idx  subkey request and index of the subkey needed
//   key_valid, subkey  subkey handshake from the key store
//   data_out           result block {x, y}, held until the next done
//   busy               high from start acceptance until done
//   done               one-cycle completion pulse
module speck_round_engine #(
  parameter int WORD_SIZE  = 16,
  parameter int ALPHA      = 7,
  parameter int BETA       = 2,
  parameter int MAX_ROUNDS = 22,
  parameter int ROUND_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decrypt,
  input  logic [ROUND_W-1:0]     num_rounds,
  input  logic [2*WORD_SIZE-1:0] data_in,
  output logic                   key_req,
  output logic [ROUND_W-1:0]     key_idx,
  input  logic                   key_valid,
  input  logic [WORD_SIZE-1:0]   subkey,
  output logic [2*WORD_SIZE-1:0] data_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    DONE
  } state_t;

  localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUNDS);

  function automatic logic [WORD_SIZE-1:0] rot_r(input logic [WORD_SIZE-1:0] v,
                                                 input int unsigned amt);
    rot_r = (v >> amt) | (v << (WORD_SIZE - amt));
  endfunction

  function automatic logic [WORD_SIZE-1:0] rot_l(input logic [WORD_SIZE-1:0] v,
                                                 input int unsigned amt);
    rot_l = (v << amt) | (v >> (WORD_SIZE - amt));
  endfunction

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   x_q, x_d;
  logic [WORD_SIZE-1:0]   y_q, y_d;
  logic [ROUND_W-1:0]     r_q, r_d;
  logic [ROUND_W-1:0]     rounds_q, rounds_d;
  logic                   dec_q, dec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [2*WORD_SIZE-1:0] data_out_q, data_out_d;

  logic [WORD_SIZE-1:0]   enc_x, enc_y, dec_x, dec_y;
  logic [ROUND_W-1:0]     rounds_sel;
  logic [ROUND_W-1:0]     r_inc;

  // Both round directions are computed every cycle; the latched mode picks one.
  always_comb begin
    enc_x = (rot_r(x_q, ALPHA) + y_q) ^ subkey;
    enc_y = rot_l(y_q, BETA) ^ enc_x;
    dec_y = rot_r(x_q ^ y_q, BETA);
    dec_x = rot_l((x_q ^ subkey) - dec_y, ALPHA);
  end

  always_comb begin
    rounds_sel = (num_rounds > MAX_R) ? MAX_R : num_rounds;
    r_inc      = r_q + ROUND_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    r_d        = r_q;
    rounds_d   = rounds_q;
    dec_d      = dec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    key_req    = 1'b0;
    key_idx    = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = data_in[2*WORD_SIZE-1:WORD_SIZE];
          y_d      = data_in[WORD_SIZE-1:0];
          dec_d    = decrypt;
          rounds_d = rounds_sel;
          r_d      = '0;
          busy_d   = 1'b1;
          state_d  = (rounds_sel == '0) ? DONE : KEY;
        end
      end

      KEY: begin
        key_req = 1'b1;
        // Decrypt walks the key schedule backwards.
        key_idx = dec_q ? (rounds_q - r_q - ROUND_W'(1)) : r_q;
        if (key_valid) begin
          x_d = dec_q ? dec_x : enc_x;
          y_d = dec_q ? dec_y : enc_y;
          r_d = r_inc;
          if (r_inc == rounds_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        data_out_d = {x_q, y_q};
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      rounds_q   <= '0;
      dec_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      r_q        <= r_d;
      rounds_q   <= rounds_d;
      dec_q      <= dec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_speck_round_engine.sv
// Testbench for speck_round_engine (default 16-bit word configuration).
// A transaction-level model computes each operation's result up front from
// the key table and tracks only how many subkeys remain; a compare process
// checks all outputs against it every cycle. Directed vectors pin literals.
module tb_speck_round_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [4:0]  num_rounds;
  logic [31:0] data_in;
  logic        key_req;
  logic [4:0]  key_idx;
  logic        key_valid;
  logic [15:0] subkey;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  speck_round_engine #(
    .WORD_SIZE (16),
    .ALPHA     (7),
    .BETA      (2),
    .MAX_ROUNDS(22),
    .ROUND_W   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .num_rounds(num_rounds),
    .data_in   (data_in),
    .key_req   (key_req),
    .key_idx   (key_idx),
    .key_valid (key_valid),
    .subkey    (subkey),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- key table and reference cipher ----------------
  logic [15:0] keys  [0:21];
  logic [15:0] sched [0:21];

  function automatic logic [15:0] m_rr(input logic [15:0] v, input int a);
    logic [31:0] t;
    t = {v, v} >> a;
    return t[15:0];
  endfunction

  function automatic logic [15:0] m_rl(input logic [15:0] v, input int a);
    return m_rr(v, 16 - a);
  endfunction

  function automatic logic [31:0] m_op(input logic dec, input int nr, input logic [31:0] blk);
    logic [15:0] x, y;
    x = blk[31:16];
    y = blk[15:0];
    for (int i = 0; i < nr; i++) begin
      if (!dec) begin
        x = 16'(m_rr(x, 7) + y) ^ keys[i];
        y = m_rl(y, 2) ^ x;
      end else begin
        y = m_rr(x ^ y, 2);
        x = m_rl(16'((x ^ keys[nr-1-i]) - y), 7);
      end
    end
    return {x, y};
  endfunction

  // ---------------- transaction model ----------------
  bit          m_init = 0;
  bit          m_busy, m_done, m_fin, m_dec;
  int          m_need, m_R;
  logic [31:0] m_res, m_dout;

  always @(posedge clk) begin
    m_init = 1;
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_fin = 0; m_need = 0; m_dout = '0; m_R = 0; m_dec = 0;
    end else if (m_fin) begin
      m_fin = 0; m_done = 1; m_busy = 0; m_dout = m_res;
    end else if (m_need > 0) begin
      if (key_valid) begin
        m_need--;
        if (m_need == 0) m_fin = 1;
      end
    end else if (start) begin
      m_R    = (int'(num_rounds) > 22) ? 22 : int'(num_rounds);
      m_dec  = decrypt;
      m_res  = m_op(decrypt, m_R, data_in);
      m_busy = 1;
      m_need = m_R;
      if (m_R == 0) m_fin = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      int used;
      logic [4:0] exp_idx;
      used    = m_R - m_need;
      exp_idx = (m_need > 0) ? (m_dec ? 5'(m_R - 1 - used) : 5'(used)) : 5'd0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("key_req", 32'(key_req), 32'(m_need > 0));
      chk("key_idx", 32'(key_idx), 32'(exp_idx));
      chk("data_out", data_out, m_dout);
    end
  end

  // ---------------- key store driver ----------------
  int stall_max  = 0;
  int stall_left = 0;
  int acc_cnt    = 0;

  always @(negedge clk) begin
    if (key_req) begin
      if (stall_left > 0) begin
        key_valid = 1'b0;
        stall_left--;
      end else begin
        key_valid  = 1'b1;
        stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      end
      subkey = (key_idx < 5'd22) ? keys[key_idx] : 16'h0000;
    end else begin
      key_valid = 1'($urandom_range(0, 1));
      subkey    = 16'($urandom);
    end
  end

  always @(posedge clk) begin
    if (key_req && key_valid) acc_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic dec, input logic [4:0] nr, input logic [31:0] din,
                        input bit mid_start, output logic [31:0] res, output int lat,
                        output logic [4:0] first_idx);
    @(negedge clk);
    start = 1'b1; decrypt = dec; num_rounds = nr; data_in = din;
    @(posedge clk);
    #1;
    first_idx  = key_idx;
    start      = 1'b0;
    decrypt    = ~dec;
    num_rounds = 5'($urandom);
    data_in    = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (mid_start && lat == 4) begin
        start = 1'b1; data_in = 32'hdeadbeef; decrypt = ~decrypt; num_rounds = 5'd1;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 1000);
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    res = data_out;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic [4:0]  fidx;
    logic [15:0] l [0:23];

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; num_rounds = '0; data_in = '0;
    key_valid = 1'b0; subkey = '0;

    keys[0] = 16'h0100; l[0] = 16'h0908; l[1] = 16'h1110; l[2] = 16'h1918;
    for (int i = 0; i < 21; i++) begin
      l[i+3]    = 16'(keys[i] + m_rr(l[i], 7)) ^ 16'(i);
      keys[i+1] = m_rl(keys[i], 2) ^ l[i+3];
    end
    for (int i = 0; i < 22; i++) sched[i] = keys[i];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_key_req", 32'(key_req), 32'd0);
    chk("rst_key_idx", 32'(key_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Speck32/64 encrypt vector
    run_op(1'b0, 5'd22, 32'h6574694c, 1'b0, res, lat, fidx);
    chk("enc_vec", res, 32'ha86842f2);
    chk("enc_latency", 32'(lat), 32'd23);
    chk("enc_first_idx", 32'(fidx), 32'd0);

    // Decrypt vector, back-to-back
    run_op(1'b1, 5'd22, 32'ha86842f2, 1'b0, res, lat, fidx);
    chk("dec_vec", res, 32'h6574694c);
    chk("dec_first_idx", 32'(fidx), 32'd21);

    // Single round with zero subkey
    for (int i = 0; i < 22; i++) keys[i] = 16'h0000;
    run_op(1'b0, 5'd1, 32'h00000001, 1'b0, res, lat, fidx);
    chk("one_enc", res, 32'h00010005);
    chk("one_enc_latency", 32'(lat), 32'd2);
    run_op(1'b1, 5'd1, 32'h00010005, 1'b0, res, lat, fidx);
    chk("one_dec", res, 32'h00000001);
    for (int i = 0; i < 22; i++) keys[i] = sched[i];

    // Zero rounds passes the block straight through
    run_op(1'b0, 5'd0, 32'h12345678, 1'b0, res, lat, fidx);
    chk("r0_data", res, 32'h12345678);
    chk("r0_latency", 32'(lat), 32'd1);

    // Round count clamps to MAX_ROUNDS
    run_op(1'b0, 5'd31, 32'h6574694c, 1'b0, res, lat, fidx);
    chk("clamp_vec", res, 32'ha86842f2);
    chk("clamp_latency", 32'(lat), 32'd23);

    // Start pulsed mid-operation is ignored
    run_op(1'b0, 5'd22, 32'h6574694c, 1'b1, res, lat, fidx);
    chk("midstart_vec", res, 32'ha86842f2);
    chk("midstart_latency", 32'(lat), 32'd23);

    // Reset at round 10 aborts without done
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; num_rounds = 5'd22; data_in = 32'h6574694c;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_data_out", data_out, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_key_req", 32'(key_req), 32'd0);
    chk("abort_key_idx", 32'(key_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_op(1'b0, 5'd22, 32'h6574694c, 1'b0, res, lat, fidx);
    chk("after_abort_vec", res, 32'ha86842f2);

    // Random subkey stalls
    stall_max = 5;
    acc_cnt   = 0;
    run_op(1'b0, 5'd22, 32'h6574694c, 1'b0, res, lat, fidx);
    chk("stall_vec", res, 32'ha86842f2);
    chk("stall_accepts", 32'(acc_cnt), 32'd22);
    stall_max = 0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/speck_round_engine.md
Name: speck_round_engine

Overview:
- Iterative, parametrised SPECK round engine that runs a programmable number of encrypt or decrypt rounds on one block.
- Supersedes the single-round decrypt unit:
  - adds an encrypt mode, a round count and a per-round subkey request/valid handshake;
  - generalises word size and rotation amounts.
- Sits between the key-schedule/subkey store and the top-level cipher controller.

Parameters:
- WORD_SIZE, 16, width n of one SPECK word; block is 2*WORD_SIZE.
- ALPHA, 7, right-rotate amount on x in encrypt (8 for n>16).
- BETA, 2, left-rotate amount on y in encrypt (3 for n>16).
- MAX_ROUNDS, 22, upper bound on rounds per operation.
- ROUND_W, 5, width of num_rounds and key_idx; must hold MAX_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- num_rounds  in  ROUND_W  rounds to run; sampled with start.
- data_in  in  2*WORD_SIZE  input block; [2n-1:n] = x, [n-1:0] = y; sampled with start.
- key_req  out  1  high while waiting for a subkey.
- key_idx  out  ROUND_W  index of the requested subkey.
- key_valid  in  1  subkey present; only meaningful while key_req = 1.
- subkey  in  WORD_SIZE  round key k.
- data_out  out  2*WORD_SIZE  result block, same packing as data_in; held until the next done.
- busy  out  1  high from start acceptance until done is asserted.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE, data_out 0, done 0, busy 0, key_req 0, key_idx 0, internal x/y/round counter 0.
- Reset has priority in every state and aborts any operation; no done is produced for the aborted operation.
- States: IDLE, KEY, DONE.
- IDLE:
  - on start = 1, latch x, y, mode and R = min(num_rounds, MAX_ROUNDS);
  - clear round counter r, set busy = 1;
  - go to KEY if R > 0, else DONE.
- KEY:
  - key_req = 1;
  - key_idx = r for encrypt, R-1-r for decrypt (combinational from r and R).
  - If key_valid = 0, hold x, y and r; waiting may last any number of cycles.
  - If key_valid = 1, apply one round with subkey in that cycle, register the new x/y and increment r.
  - When r reaches R, go to DONE.
- Encrypt round: x' = (ROR(x, ALPHA) + y) ^ k; y' = ROL(y, BETA) ^ x'.
- Decrypt round: y' = ROR(x ^ y, BETA); x' = ROL((x ^ k) - y', ALPHA).
- Arithmetic: addition/subtraction is modulo 2^WORD_SIZE, carries/borrows discarded. Rotations are true rotations of exactly WORD_SIZE bits.
- DONE:
  - data_out <= {x, y}; done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
  - A start in the following IDLE cycle is accepted, giving back-to-back operation.
- Latency: with key_valid held high, done is high R+1 cycles after the edge that accepted start. R = 0 gives done after 1 cycle, with data_out = data_in.
- start while busy is ignored; it is neither queued nor allowed to corrupt state.
- key_valid outside KEY has no effect.
- data_out changes only on the DONE transition or on reset.
- Mode, R and data are frozen for the whole operation; input changes after acceptance have no effect.

Test Plan:
- Speck32/64 encrypt vector: decrypt=0, R=22, data_in 32'h6574694c, subkeys from bench key schedule of key 1918_1110_0908_0100, key_valid always 1 -> data_out 32'ha86842f2, done exactly 23 cycles after the accepting edge, busy low on the done cycle.
- Decrypt vector: decrypt=1, data_in 32'ha86842f2, same key -> key_idx sequence 21..0, data_out 32'h6574694c.
- Single round, k=0: encrypt 32'h00000001 -> 32'h00010005; then decrypt 32'h00010005 -> 32'h00000001.
- Random key_valid stalls (0-5 cycles per round) on the encrypt vector -> identical data_out, key_idx stable during each stall, exactly 22 key acceptances.
- R=0 -> data_out = data_in, done 1 cycle after start. num_rounds = 31 with MAX_ROUNDS = 22 -> exactly 22 rounds are run.
- start pulsed mid-operation -> ignored, result unchanged. rst asserted at round 10 -> next cycle all outputs 0, state IDLE, no done pulse; a new start then completes normally.
